// File: rtl/sram_bus_ctrl.sv
// Bus slave for BANKS async SRAM chips on a shared bus; reads fetch two consecutive words.
// Latency: read 1+2*RD_WAIT stall cycles, write WR_WAIT+3, zero-mask write 1; stall drops in DONE.
module sram_bus_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int BANKS   = 2,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       data_wr,
  input  logic [3:0]        mask,
  output logic              stall,
  output logic [31:0]       data_rd,
  output logic [31:0]       data_rd_2,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe,
  output logic [3:0]        sram_be_n,
  output logic [BANKS-1:0]  sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int MAXW      = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W     = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  word_in, lat_word, op_word;
  logic [BW-1:0]      bank_in, lat_bank, op_bank;
  logic [31:0]        lat_data, op_data;
  logic [3:0]         lat_mask, op_mask;
  logic [BANKS-1:0]   ce_sel;
  logic               unused_addr;

  assign word_in     = address[ADDR_W+1:2];
  assign unused_addr = ^{address[31:ADDR_W+BANK_BITS+2], address[1:0]};

  generate
    if (BANKS > 1) begin : g_bank
      assign bank_in = address[ADDR_W+BANK_BITS+1:ADDR_W+2];
    end else begin : g_nobank
      assign bank_in = 1'b0;
    end
  endgenerate

  // Request fields come straight from the bus on the accepting cycle, from the latch afterwards,
  // so a master dropping its request mid-operation cannot corrupt the access.
  assign op_word = (state == IDLE) ? word_in : lat_word;
  assign op_bank = (state == IDLE) ? bank_in : lat_bank;
  assign op_data = (state == IDLE) ? data_wr : lat_data;
  assign op_mask = (state == IDLE) ? mask    : lat_mask;

  always_comb begin
    ce_sel          = '1;
    ce_sel[op_bank] = 1'b0;
  end

  assign stall = (read | write) & (state != DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write)     state_nxt = (mask == 4'h0) ? DONE : WR_SETUP;
        else if (read) state_nxt = RD1;
      end
      RD1:      if (cnt == CNT_W'(RD_WAIT - 1)) state_nxt = RD2;
      RD2:      if (cnt == CNT_W'(RD_WAIT - 1)) state_nxt = DONE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt == CNT_W'(WR_WAIT - 1)) state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Pad controls are registered from the next state so every strobe is glitch-free and
  // lines up exactly with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_word     <= '0;
      lat_bank     <= '0;
      lat_data     <= '0;
      lat_mask     <= '0;
      data_rd      <= '0;
      data_rd_2    <= '0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_be_n    <= 4'hF;
      sram_ce_n    <= '1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE || state == DONE) cnt <= '0;
      else                                                      cnt <= cnt + CNT_W'(1);

      if (state == IDLE) begin
        lat_word <= word_in;
        lat_bank <= bank_in;
        lat_data <= data_wr;
        lat_mask <= mask;
      end

      if (state == RD1 && state_nxt == RD2)  data_rd   <= sram_data_i;
      if (state == RD2 && state_nxt == DONE) data_rd_2 <= sram_data_i;

      case (state_nxt)
        RD1, RD2: begin
          sram_ce_n    <= ce_sel;
          sram_oe_n    <= 1'b0;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'h0;
          sram_data_oe <= 1'b0;
          sram_addr    <= (state_nxt == RD2) ? op_word + ADDR_W'(1) : op_word;
        end
        WR_SETUP, WR_PULSE, WR_HOLD: begin
          sram_ce_n    <= ce_sel;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= (state_nxt != WR_PULSE);
          sram_be_n    <= ~op_mask;
          sram_data_oe <= 1'b1;
          sram_addr    <= op_word;
          sram_data_o  <= op_data;
        end
        default: begin
          sram_ce_n    <= '1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'hF;
          sram_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl with a behavioural two-bank async SRAM model.
module tb_sram_bus_ctrl;
  localparam int ADDR_W = 4;
  localparam int BANKS  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       address;
  logic              read, write;
  logic [31:0]       data_wr;
  logic [3:0]        mask;
  logic              stall;
  logic [31:0]       data_rd, data_rd_2;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_data_o, sram_data_i;
  logic              sram_data_oe;
  logic [3:0]        sram_be_n;
  logic [BANKS-1:0]  sram_ce_n;
  logic              sram_oe_n, sram_we_n;

  logic [31:0] mem [0:31];
  int n_cmp = 0;
  int n_err = 0;
  int conflicts = 0;

  sram_bus_ctrl #(.ADDR_W(ADDR_W), .BANKS(BANKS), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
    .data_wr(data_wr), .mask(mask), .stall(stall), .data_rd(data_rd), .data_rd_2(data_rd_2),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .sram_data_oe(sram_data_oe), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  always_comb begin
    sram_data_i = 32'h0;
    if (!sram_oe_n) begin
      if (!sram_ce_n[0])      sram_data_i = mem[{1'b0, sram_addr}];
      else if (!sram_ce_n[1]) sram_data_i = mem[{1'b1, sram_addr}];
    end
  end

  always @(posedge clk) begin
    if (!sram_we_n && sram_ce_n != 2'b11 && sram_data_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[{!sram_ce_n[1], sram_addr}][8*b +: 8] = sram_data_o[8*b +: 8];
    end
  end

  always @(negedge clk) if (!sram_oe_n && sram_data_oe) conflicts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues a request and returns at the first falling edge with stall low (the DONE cycle).
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input logic [1:0] ce_exp,
                         output int st, output int wl, output int cl, output int cbad,
                         output logic [3:0] be_w);
    st = 0; wl = 0; cl = 0; cbad = 0; be_w = 4'hF;
    @(posedge clk); #1;
    read = rd; write = wr; address = a; data_wr = d; mask = m;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin wl++; be_w = sram_be_n; end
      if (sram_ce_n != 2'b11) begin
        cl++;
        if (sram_ce_n != ce_exp) cbad++;
      end
      if (stall) st++;
      else break;
    end
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    int st, wl, cl, cbad;
    logic [3:0] be_w;
    rst_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_wr = '0; mask = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[5]  = 32'hAAAA_0005;  mem[6]  = 32'hBBBB_0006;
    mem[31] = 32'hC0C0_001F;  mem[16] = 32'hD0D0_0010;
    mem[8]  = 32'h1122_3344;  mem[9]  = 32'h0000_0055;
    mem[11] = 32'h1234_5678;

    #12;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_data_rd", data_rd, 32'h0);
    chk("rst_data_rd_2", data_rd_2, 32'h0);
    chk("rst_addr", {28'b0, sram_addr}, 32'h0);
    chk("rst_data_o", sram_data_o, 32'h0);
    chk("rst_data_oe", {31'b0, sram_data_oe}, 32'h0);
    chk("rst_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("rst_ce_n", {30'b0, sram_ce_n}, 32'h3);
    chk("rst_oe_n", {31'b0, sram_oe_n}, 32'h1);
    chk("rst_we_n", {31'b0, sram_we_n}, 32'h1);
    @(negedge clk); rst_n = 1'b1;

    // Read word 5 of bank 0: words 5 and 6.
    run_req(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 2'b10, st, wl, cl, cbad, be_w);
    chk("rd_stall_cycles", st, 5);
    chk("rd_data_rd", data_rd, 32'hAAAA_0005);
    chk("rd_data_rd_2", data_rd_2, 32'hBBBB_0006);
    chk("rd_ce_cycles", cl, 4);
    chk("rd_ce_bank", cbad, 0);
    chk("rd_done_oe_n", {31'b0, sram_oe_n}, 32'h1);
    end_req();

    // Last word of bank 1 wraps to bank 1 word 0.
    run_req(1'b1, 1'b0, 32'h7C, 32'h0, 4'h0, 2'b01, st, wl, cl, cbad, be_w);
    chk("wrap_data_rd", data_rd, 32'hC0C0_001F);
    chk("wrap_data_rd_2", data_rd_2, 32'hD0D0_0010);
    chk("wrap_ce_bank", cbad, 0);
    chk("wrap_ce_cycles", cl, 4);
    end_req();

    // Partial write of bytes 0 and 2 into bank 0 word 8.
    run_req(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0101, 2'b10, st, wl, cl, cbad, be_w);
    chk("wr_stall_cycles", st, 5);
    chk("wr_we_low_cycles", wl, 2);
    chk("wr_be_n", {28'b0, be_w}, 32'hA);
    chk("wr_ce_bank", cbad, 0);
    chk("wr_done_data_oe", {31'b0, sram_data_oe}, 32'h0);
    end_req();
    chk("wr_mem", mem[8], 32'h11AD_33EF);
    chk("wr_data_rd_kept", data_rd, 32'hC0C0_001F);

    // Zero-mask write touches nothing.
    run_req(1'b0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 2'b10, st, wl, cl, cbad, be_w);
    chk("zm_stall_cycles", st, 1);
    chk("zm_we_low_cycles", wl, 0);
    chk("zm_ce_cycles", cl, 0);
    end_req();
    chk("zm_mem", mem[9], 32'h0000_0055);

    // Read and write together behave as a write.
    run_req(1'b1, 1'b1, 32'h28, 32'hCAFE_F00D, 4'hF, 2'b10, st, wl, cl, cbad, be_w);
    chk("rw_stall_cycles", st, 5);
    chk("rw_we_low_cycles", wl, 2);
    chk("rw_data_rd_kept", data_rd, 32'hC0C0_001F);
    chk("rw_data_rd_2_kept", data_rd_2, 32'hD0D0_0010);
    end_req();
    chk("rw_mem", mem[10], 32'hCAFE_F00D);

    run_req(1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 2'b10, st, wl, cl, cbad, be_w);
    chk("rb_data_rd", data_rd, 32'hCAFE_F00D);
    chk("rb_data_rd_2", data_rd_2, 32'h1234_5678);
    end_req();

    // Reset asserted while we_n is low.
    @(posedge clk); #1;
    write = 1'b1; address = 32'h30; data_wr = 32'h5555_AAAA; mask = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) break;
    end
    chk("rst_mid_we_seen", {31'b0, sram_we_n}, 32'h0);
    rst_n = 1'b0; #1;
    chk("rst_mid_we_n", {31'b0, sram_we_n}, 32'h1);
    chk("rst_mid_ce_n", {30'b0, sram_ce_n}, 32'h3);
    chk("rst_mid_data_oe", {31'b0, sram_data_oe}, 32'h0);
    write = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("post_rst_stall", {31'b0, stall}, 32'h0);
    run_req(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 2'b10, st, wl, cl, cbad, be_w);
    chk("post_rst_rd_stall", st, 5);
    chk("post_rst_rd_data", data_rd, 32'hAAAA_0005);
    end_req();

    chk("oe_vs_data_oe_conflicts", conflicts, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
